// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: tracks ID/EX, EX/MEM and MEM/WB register tags to steer
// operand forwarding, detect load-use stalls and insert bubbles on taken branches.
module hazard_forward_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        ex_branch_taken,
  output logic [1:0]  forward_a_sel,
  output logic [1:0]  forward_b_sel,
  output logic        stall,
  output logic        flush_ifid,
  output logic [15:0] stall_count
);

  logic [4:0]  idexRs1_q, idexRs2_q, idexRd_q;
  logic        idexUseRs1_q, idexUseRs2_q, idexRegwrite_q, idexMemread_q, idexValid_q;
  logic [4:0]  idexRs1_d, idexRs2_d, idexRd_d;
  logic        idexUseRs1_d, idexUseRs2_d, idexRegwrite_d, idexMemread_d, idexValid_d;

  logic [4:0]  exmemRd_q, memwbRd_q;
  logic        exmemRegwrite_q, exmemValid_q, memwbRegwrite_q, memwbValid_q;

  logic [15:0] stallCount_q, stallCount_d;

  logic        exmemCand, memwbCand, loadUse, bubble;

  // A stage only forwards if it really writes a non-x0 register.
  assign exmemCand = exmemValid_q & exmemRegwrite_q & (exmemRd_q != 5'd0);
  assign memwbCand = memwbValid_q & memwbRegwrite_q & (memwbRd_q != 5'd0);

  always_comb begin
    forward_a_sel = 2'b00;
    if (idexUseRs1_q && exmemCand && (exmemRd_q == idexRs1_q))
      forward_a_sel = 2'b10;
    else if (idexUseRs1_q && memwbCand && (memwbRd_q == idexRs1_q))
      forward_a_sel = 2'b01;

    forward_b_sel = 2'b00;
    if (idexUseRs2_q && exmemCand && (exmemRd_q == idexRs2_q))
      forward_b_sel = 2'b10;
    else if (idexUseRs2_q && memwbCand && (memwbRd_q == idexRs2_q))
      forward_b_sel = 2'b01;
  end

  assign loadUse = id_valid & idexValid_q & idexMemread_q & (idexRd_q != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == idexRd_q)) |
                    (id_use_rs2 & (id_rs2 == idexRd_q)));

  // A taken branch already kills the dependent instruction, so it overrides the stall.
  assign bubble     = loadUse | ex_branch_taken;
  assign stall      = loadUse & ~ex_branch_taken;
  assign flush_ifid = ex_branch_taken;

  always_comb begin
    idexRs1_d      = id_rs1;
    idexRs2_d      = id_rs2;
    idexRd_d       = id_rd;
    idexUseRs1_d   = id_use_rs1;
    idexUseRs2_d   = id_use_rs2;
    idexRegwrite_d = id_regwrite;
    idexMemread_d  = id_memread;
    idexValid_d    = id_valid;
    if (bubble) begin
      idexRs1_d      = 5'd0;
      idexRs2_d      = 5'd0;
      idexRd_d       = 5'd0;
      idexUseRs1_d   = 1'b0;
      idexUseRs2_d   = 1'b0;
      idexRegwrite_d = 1'b0;
      idexMemread_d  = 1'b0;
      idexValid_d    = 1'b0;
    end
  end

  assign stallCount_d = (stall && (stallCount_q != 16'hFFFF)) ? stallCount_q + 16'd1
                                                               : stallCount_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idexRs1_q       <= 5'd0;
      idexRs2_q       <= 5'd0;
      idexRd_q        <= 5'd0;
      idexUseRs1_q    <= 1'b0;
      idexUseRs2_q    <= 1'b0;
      idexRegwrite_q  <= 1'b0;
      idexMemread_q   <= 1'b0;
      idexValid_q     <= 1'b0;
      exmemRd_q       <= 5'd0;
      exmemRegwrite_q <= 1'b0;
      exmemValid_q    <= 1'b0;
      memwbRd_q       <= 5'd0;
      memwbRegwrite_q <= 1'b0;
      memwbValid_q    <= 1'b0;
      stallCount_q    <= 16'd0;
    end else begin
      idexRs1_q       <= idexRs1_d;
      idexRs2_q       <= idexRs2_d;
      idexRd_q        <= idexRd_d;
      idexUseRs1_q    <= idexUseRs1_d;
      idexUseRs2_q    <= idexUseRs2_d;
      idexRegwrite_q  <= idexRegwrite_d;
      idexMemread_q   <= idexMemread_d;
      idexValid_q     <= idexValid_d;
      exmemRd_q       <= idexRd_q;
      exmemRegwrite_q <= idexRegwrite_q;
      exmemValid_q    <= idexValid_q;
      memwbRd_q       <= exmemRd_q;
      memwbRegwrite_q <= exmemRegwrite_q;
      memwbValid_q    <= exmemValid_q;
      stallCount_q    <= stallCount_d;
    end
  end

  assign stall_count = stallCount_q;

endmodule
